// File: rtl/alu_pkg.sv
// Shared operation codes and shifter mode for the MIPS-style ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    typedef enum logic [1:0] {
        SH_SRA = 2'b00,
        SH_SRL = 2'b01,
        SH_SLL = 2'b10
    } shift_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter returning the shifted value and the last bit shifted out.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         value,
    input  logic [$clog2(WIDTH)-1:0] amount,
    input  shift_op_t                op,
    output logic [WIDTH-1:0]         result,
    output logic                     carry
);

    logic [WIDTH:0] right_ext;
    logic [WIDTH:0] left_ext;

    // A guard bit beside the value catches the last bit shifted out; amount 0 leaves it at 0.
    always_comb begin
        right_ext = '0;
        left_ext  = '0;
        result    = '0;
        carry     = 1'b0;
        case (op)
            SH_SRA: begin
                right_ext = $signed({value, 1'b0}) >>> amount;
                result    = right_ext[WIDTH:1];
                carry     = right_ext[0];
            end
            SH_SRL: begin
                right_ext = {value, 1'b0} >> amount;
                result    = right_ext[WIDTH:1];
                carry     = right_ext[0];
            end
            default: begin
                left_ext = {1'b0, value} << amount;
                result   = left_ext[WIDTH-1:0];
                carry    = left_ext[WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// MIPS-style integer ALU with registered result and flags (one-cycle latency).
// Optional feature macro: ALU_STICKY_OVF_EN adds the ovf_sticky output.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
`ifdef ALU_STICKY_OVF_EN
    ,
    output logic             ovf_sticky
`endif
);

    logic             sub_op;
    logic [WIDTH:0]   sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt_u;
    logic             lt_s;
    shift_op_t        shift_op;
    logic [WIDTH-1:0] shift_result;
    logic             shift_carry;
    logic [WIDTH-1:0] r_next;
    logic             zero_next;
    logic             carry_next;
    logic             negative_next;
    logic             overflow_next;

    // SLT/SLTU reuse the subtractor: carry-out gives unsigned compare, sign^overflow gives signed.
    assign sub_op  = (aluc[3:2] == 2'b00) ? aluc[0] : 1'b1;
    assign sum     = {1'b0, a} + {1'b0, b ^ {WIDTH{sub_op}}} + {{WIDTH{1'b0}}, sub_op};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign lt_u    = ~sum[WIDTH];
    assign lt_s    = sum[WIDTH-1] ^ sub_ovf;

    assign shift_op = aluc[1] ? SH_SLL : (aluc[0] ? SH_SRL : SH_SRA);

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .value  (b),
        .amount (a[$clog2(WIDTH)-1:0]),
        .op     (shift_op),
        .result (shift_result),
        .carry  (shift_carry)
    );

    always_comb begin
        r_next        = '0;
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (aluc)
            ALU_ADDU: begin
                r_next     = sum[WIDTH-1:0];
                carry_next = sum[WIDTH];
            end
            ALU_ADD: begin
                r_next        = sum[WIDTH-1:0];
                overflow_next = add_ovf;
            end
            ALU_SUBU: begin
                r_next     = sum[WIDTH-1:0];
                carry_next = lt_u;
            end
            ALU_SUB: begin
                r_next        = sum[WIDTH-1:0];
                overflow_next = sub_ovf;
            end
            ALU_AND: r_next = a & b;
            ALU_OR:  r_next = a | b;
            ALU_XOR: r_next = a ^ b;
            ALU_NOR: r_next = ~(a | b);
            ALU_LUI, ALU_LUI | 4'b0001: r_next = {b[15:0], {(WIDTH-16){1'b0}}};
            ALU_SLTU: begin
                r_next     = {{(WIDTH-1){1'b0}}, lt_u};
                carry_next = lt_u;
            end
            ALU_SLT: r_next = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLL | 4'b0001: begin
                r_next     = shift_result;
                carry_next = shift_carry;
            end
            default: r_next = '0;
        endcase
        zero_next     = ((aluc == ALU_SLT) || (aluc == ALU_SLTU)) ? (a == b) : (r_next == '0);
        negative_next = (aluc == ALU_SLT) ? lt_s : r_next[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r        <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            r        <= r_next;
            zero     <= zero_next;
            carry    <= carry_next;
            negative <= negative_next;
            overflow <= overflow_next;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    // Set in the same cycle the registered overflow rises; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else begin
            ovf_sticky <= ovf_sticky | overflow_next;
        end
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed results, a monitor checks them one edge later.
module tb_alu;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [31:0] r;
        logic        zero;
        logic        carry;
        logic        negative;
        logic        overflow;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [31:0] r;
    logic        zero;
    logic        carry;
    logic        negative;
    logic        overflow;

    logic        issued;
    exp_t        sb[$];
    int          checks;
    int          errors;

    alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .aluc     (aluc),
        .r        (r),
        .zero     (zero),
        .carry    (carry),
        .negative (negative),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [35:0] actual, input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got r=%h z=%b c=%b n=%b v=%b, want r=%h z=%b c=%b n=%b v=%b",
                     name, actual[35:4], actual[3], actual[2], actual[1], actual[0],
                     expected[35:4], expected[3], expected[2], expected[1], expected[0]);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic ez, input logic ec, input logic en, input logic eo);
        exp_t e;
        a      = av;
        b      = bv;
        aluc   = op;
        e.aluc = op;
        e.r    = er;
        e.zero = ez;
        e.carry = ec;
        e.negative = en;
        e.overflow = eo;
        sb.push_back(e);
        issued = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  input logic [31:0] er, input logic ez, input logic ec, input logic en, input logic eo);
        @(negedge clk);
        drive(op, av, bv, er, ez, ec, en, eo);
    endtask

    always @(posedge clk) begin
        if (issued) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underflow: got an output with no expected entry, want a queued entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output($sformatf("aluc_%b", e.aluc), {r, zero, carry, negative, overflow},
                             {e.r, e.zero, e.carry, e.negative, e.overflow});
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        issued = 1'b0;
        a      = '0;
        b      = '0;
        aluc   = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_output("reset_init", {r, zero, carry, negative, overflow}, 36'h0);
        @(posedge clk);
        #1 check_output("reset_held", {r, zero, carry, negative, overflow}, 36'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //             op       a             b             r             z     c     n     v
        apply_stimulus(4'b0000, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b0000, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);
        apply_stimulus(4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0010, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b0001, 32'h00000001, 32'hffffffff, 32'h00000002, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b0001, 32'h00000005, 32'h00000007, 32'hfffffffe, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(4'b0001, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b0011, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(4'b0011, 32'h00000005, 32'h00000007, 32'hfffffffe, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b0100, 32'hffffffff, 32'haaaaaaaa, 32'haaaaaaaa, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b0101, 32'hffffffff, 32'haaaaaaaa, 32'hffffffff, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b0110, 32'hffffffff, 32'haaaaaaaa, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b0111, 32'hffffffff, 32'haaaaaaaa, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1000, 32'hffffffff, 32'haaaaaaaa, 32'haaaa0000, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b1001, 32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1011, 32'hffffffff, 32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b1010, 32'hffffffff, 32'h7fffffff, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1011, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1011, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b1011, 32'h7fffffff, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1010, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b1100, 32'h00000010, 32'hf1234567, 32'hfffff123, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b1101, 32'h00000010, 32'hf1234567, 32'h0000f123, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1110, 32'h00000010, 32'hf1234567, 32'h45670000, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b1111, 32'h00000010, 32'hf1234567, 32'h45670000, 1'b0, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b1100, 32'h00000001, 32'h80000001, 32'hc0000000, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(4'b1101, 32'h00000000, 32'h80000001, 32'h80000001, 1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(4'b1110, 32'h0000001f, 32'h00000003, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0);
        apply_stimulus(4'b1101, 32'hffffffe0, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b1101, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Assert reset between edges while the outputs hold a non-zero result.
        @(negedge clk);
        issued = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_output("reset_mid", {r, zero, carry, negative, overflow}, 36'h0);
        @(posedge clk);
        #1 check_output("reset_mid_held", {r, zero, carry, negative, overflow}, 36'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4'b0011, 32'h00000004, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        issued = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
